// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-atomic write-port arbiter for the async FIFO.
// Write-clock domain only; drives i_wData/i_wEN directly.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          o_Full,
  output logic [DATA_WIDTH-1:0]         i_wData,
  output logic                          i_wEN,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic              accept;
  logic              in_grant;
  logic              release_now;

  assign in_grant = (state_q == GRANT);
  assign accept   = in_grant & req_valid[owner_q] & ~o_Full;

  // Round-robin pick: scan starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Write-port datapath driven by the current owner.
  always_comb begin
    req_ready = '0;
    i_wData   = '0;
    if (in_grant) begin
      req_ready = o_Full ? '0 : grant_q;
      i_wData   = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign i_wEN   = accept;
  assign o_grant = grant_q;
  assign o_busy  = in_grant;

  assign release_now = in_grant &
    (~req_valid[owner_q] |
     (accept & (req_last[owner_q] |
                (cnt_q == CW'(MAX_BURST - 1)))));

  // Next-state: grant on arbitration, count beats, release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
